// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity state and bit).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    // start + 8 data + parity + stop
    localparam int unsigned UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;
`else
    // start + 8 data + stop (8N1)
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } uart_tx_state_e;
`endif

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Ports: clk_i, rst_i (async active-high), push_i/wdata_i write side,
// pop_i/head_c read side (head_c is the combinational head entry),
// ready_o (registered not-full), empty_o (registered), level_o (occupancy).
module uart_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_c,
    output logic                       ready_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [LVL_W-1:0] level_next;

    // A full FIFO ignores pushes even when a pop frees a slot this cycle.
    assign push_ok    = push_i && ready_o;
    assign pop_ok     = pop_i && !empty_o;
    assign level_next = level_o + LVL_W'(push_ok) - LVL_W'(pop_ok);
    assign head_c     = mem[rd_ptr];

    // Storage array; no reset needed, contents are qualified by the level.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
            ready_o <= 1'b1;
            empty_o <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_o <= level_next;
            ready_o <= (level_next != LVL_W'(DEPTH));
            empty_o <= (level_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8-bit LSB-first frames with start/stop bits, runtime
// baud divider and an internal TX FIFO.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after bit 7.
// Ports: clk_i, rst_i (async active-high), cfg_en_i (gates new frames),
// cfg_div_i (bit period minus one), data_i/valid_i/ready_o (byte push),
// tx_o (serial line, idle high), busy_o (frame on the line),
// fifo_level_o (FIFO occupancy).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_en_i,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    uart_tx_state_e              state;
    logic [DIV_WIDTH-1:0]        div_q;
    logic [DIV_WIDTH-1:0]        baud_cnt;
    logic [2:0]                  bit_cnt;
    logic [UART_DATA_BITS-1:0]   shift_q;
    logic [UART_DATA_BITS-1:0]   fifo_head;
    logic                        fifo_empty;
    logic                        bit_end_c;
    logic                        pop_c;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q;
`endif

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (valid_i),
        .wdata_i (data_i),
        .pop_i   (pop_c),
        .head_c  (fifo_head),
        .ready_o (ready_o),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign bit_end_c = (baud_cnt == div_q);

    // Pop from IDLE, or at the final stop-bit cycle for gapless back-to-back frames.
    assign pop_c = cfg_en_i && !fifo_empty &&
                   ((state == IDLE) || ((state == STOP) && bit_end_c));

    // FSM, baud/bit counters and shift register. tx_o/busy_o are registered
    // from the current state, so the line trails the state by one cycle and
    // busy_o brackets exactly the cycles the frame occupies on the line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            busy_o <= (state != IDLE);

            case (state)
                START:   tx_o <= 1'b0;
                DATA:    tx_o <= shift_q[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  tx_o <= parity_q;
`endif
                default: tx_o <= 1'b1;
            endcase

            if ((state == IDLE) || bit_end_c) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (pop_c) begin
                        shift_q <= fifo_head;
                        div_q   <= cfg_div_i;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^fifo_head;
`endif
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end_c) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        shift_q <= shift_q >> 1;
                        bit_cnt <= bit_cnt + 3'(1);
                        if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end_c) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end_c) begin
                        if (pop_c) begin
                            shift_q <= fifo_head;
                            div_q   <= cfg_div_i;
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^fifo_head;
`endif
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned DEPTH = 8;

    logic             clk;
    logic             rst_i;
    logic             cfg_en;
    logic [DIV_W-1:0] cfg_div;
    logic [7:0]       data;
    logic             valid;
    logic             ready;
    logic             tx;
    logic             busy;
    logic [3:0]       level;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DIV_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_en_i     (cfg_en),
        .cfg_div_i    (cfg_div),
        .data_i       (data),
        .valid_i      (valid),
        .ready_o      (ready),
        .tx_o         (tx),
        .busy_o       (busy),
        .fifo_level_o (level)
    );

    // 50 MHz
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line bits of one frame, index 0 = start bit.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    // Samples one frame (per cycles per bit); bit value taken at the first
    // cycle of each period, later cycles that differ are counted as unstable.
    task automatic get_frame(input int per, input int chg_at, input logic [DIV_W-1:0] new_div,
                             output logic [10:0] bits, output int unstable, output int busy_low);
        bits     = '1;
        unstable = 0;
        busy_low = 0;
        for (int c = 0; c < per * int'(UART_FRAME_BITS); c++) begin
            if (c == chg_at) cfg_div = new_div;
            tick();
            if (c % per == 0) bits[c / per] = tx;
            else if (tx !== bits[c / per]) unstable++;
            if (busy !== 1'b1) busy_low++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cfg_en = 1'b0; cfg_div = '0; data = '0; valid = 1'b0;
        repeat (3) tick();
        total_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else pass_cnt++;
        total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (level !== 4'd0) $display("FAIL reset_level: got %0d expected 0", level); else pass_cnt++;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_frame_55();
        logic [10:0] bits;
        int unst, blow;
        cfg_en = 1'b1; cfg_div = 16'd3;
        data = 8'h55; valid = 1'b1;
        tick();                         // push edge
        valid = 1'b0;
        total_cnt++; if (level !== 4'd1) $display("FAIL f55_level: got %0d expected 1", level); else pass_cnt++;
        tick();                         // pop edge, line still idle
        total_cnt++; if (tx !== 1'b1) $display("FAIL f55_idle_before_start: got %b expected 1", tx); else pass_cnt++;
        get_frame(4, -1, '0, bits, unst, blow);
        total_cnt++; if (bits !== exp_frame(8'h55)) $display("FAIL f55_bits: got %b expected %b", bits, exp_frame(8'h55)); else pass_cnt++;
        total_cnt++; if (unst !== 0) $display("FAIL f55_bit_width: got %0d unstable samples expected 0", unst); else pass_cnt++;
        total_cnt++; if (blow !== 0) $display("FAIL f55_busy: got %0d busy-low samples expected 0", blow); else pass_cnt++;
        tick();
        total_cnt++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL f55_after: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits;
        int unst, blow;
        cfg_en = 1'b0; cfg_div = 16'd1;
        for (int i = 0; i < 9; i++) begin
            data = 8'(i + 1); valid = 1'b1;
            if (i == 8) begin
                total_cnt++; if (ready !== 1'b0) $display("FAIL b2b_ready_full: got %b expected 0", ready); else pass_cnt++;
            end
            tick();
        end
        valid = 1'b0;
        total_cnt++; if (level !== 4'd8) $display("FAIL b2b_level: got %0d expected 8", level); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL b2b_disabled_idle: got busy=%b tx=%b expected 0/1", busy, tx); else pass_cnt++;
        cfg_en = 1'b1;
        tick();                         // pop edge
        for (int f = 0; f < 8; f++) begin
            get_frame(2, -1, '0, bits, unst, blow);
            total_cnt++;
            if (bits !== exp_frame(8'(f + 1)) || unst !== 0 || blow !== 0)
                $display("FAIL b2b_frame%0d: got %b (unstable %0d busy-low %0d) expected %b", f, bits, unst, blow, exp_frame(8'(f + 1)));
            else pass_cnt++;
        end
        tick();
        total_cnt++; if (tx !== 1'b1 || busy !== 1'b0 || level !== 4'd0)
            $display("FAIL b2b_drained: got tx=%b busy=%b level=%0d expected 1/0/0", tx, busy, level); else pass_cnt++;
    endtask

    task automatic test_div_change();
        logic [10:0] bits;
        int unst, blow;
        cfg_en = 1'b1; cfg_div = 16'd3;
        data = 8'hA3; valid = 1'b1;
        tick();
        data = 8'h3C;
        tick();                         // second push, first pop
        valid = 1'b0;
        get_frame(4, 5, 16'd7, bits, unst, blow);
        total_cnt++; if (bits !== exp_frame(8'hA3) || unst !== 0)
            $display("FAIL div_a3_frame: got %b (unstable %0d) expected %b", bits, unst, exp_frame(8'hA3)); else pass_cnt++;
        get_frame(8, -1, '0, bits, unst, blow);
        total_cnt++; if (bits !== exp_frame(8'h3C) || unst !== 0)
            $display("FAIL div_3c_frame: got %b (unstable %0d) expected %b", bits, unst, exp_frame(8'h3C)); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL div_after_busy: got %b expected 0", busy); else pass_cnt++;
        cfg_div = 16'd3;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] q [4];
        int tx_low, busy_hi;
        q[0] = 8'hFF; q[1] = 8'h11; q[2] = 8'h22; q[3] = 8'h33;
        cfg_en = 1'b1; cfg_div = 16'd3;
        for (int i = 0; i < 4; i++) begin
            data = q[i]; valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        // start began after the 3rd tick; advance into data bit 4 (line bit 5)
        repeat (19) tick();
        total_cnt++; if (busy !== 1'b1 || level !== 4'd3)
            $display("FAIL rst_pre: got busy=%b level=%0d expected 1/3", busy, level); else pass_cnt++;
        #4 rst_i = 1'b1;
        #1;
        total_cnt++; if (tx !== 1'b1 || busy !== 1'b0 || level !== 4'd0 || ready !== 1'b1)
            $display("FAIL rst_async: got tx=%b busy=%b level=%0d ready=%b expected 1/0/0/1", tx, busy, level, ready); else pass_cnt++;
        tick(); tick();
        rst_i = 1'b0;
        tx_low = 0; busy_hi = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
        end
        total_cnt++; if (tx_low !== 0 || busy_hi !== 0 || level !== 4'd0)
            $display("FAIL rst_no_frames: got tx-low=%0d busy-high=%0d level=%0d expected 0/0/0", tx_low, busy_hi, level); else pass_cnt++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [10:0] bits;
        int unst, blow;
        logic [7:0] v [2];
        logic exp_par [2];
        v[0] = 8'h07; exp_par[0] = 1'b1;
        v[1] = 8'h03; exp_par[1] = 1'b0;
        cfg_en = 1'b1; cfg_div = 16'd1;
        for (int i = 0; i < 2; i++) begin
            data = v[i]; valid = 1'b1;
            tick();
            valid = 1'b0;
            tick();
            get_frame(2, -1, '0, bits, unst, blow);
            total_cnt++; if (bits[9] !== exp_par[i] || bits !== exp_frame(v[i]) || unst !== 0)
                $display("FAIL parity_%02h: got %b expected %b", v[i], bits, exp_frame(v[i])); else pass_cnt++;
            tick();
            total_cnt++; if (busy !== 1'b0) $display("FAIL parity_len_%02h: busy got %b expected 0 after 11 bits", v[i], busy); else pass_cnt++;
        end
    endtask
`endif

    task automatic test_loopback();
        string msg;
        logic [7:0] rx_b;
        int wait_c, bad_stop, bad_start, timeouts;
        string got;
        msg = "Hello\n";
        got = "";
        bad_stop = 0; bad_start = 0; timeouts = 0;
        cfg_en = 1'b1; cfg_div = 16'd433;
        for (int i = 0; i < msg.len(); i++) begin
            data = msg[i]; valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        for (int i = 0; i < msg.len(); i++) begin
            wait_c = 0;
            while (tx !== 1'b0 && wait_c < 20000) begin
                tick();
                wait_c++;
            end
            if (wait_c >= 20000) begin
                timeouts++;
                break;
            end
            repeat (217) tick();
            if (tx !== 1'b0) bad_start++;
            for (int k = 0; k < 8; k++) begin
                repeat (434) tick();
                rx_b[k] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (434) tick();
`endif
            repeat (434) tick();
            if (tx !== 1'b1) bad_stop++;
            got = {got, string'(rx_b)};
        end
        total_cnt++; if (timeouts !== 0) $display("FAIL loop_timeout: got %0d timeouts expected 0", timeouts); else pass_cnt++;
        total_cnt++; if (got != msg) $display("FAIL loop_text: got \"%s\" expected \"%s\"", got, msg); else pass_cnt++;
        total_cnt++; if (bad_start !== 0 || bad_stop !== 0)
            $display("FAIL loop_framing: got bad-start=%0d bad-stop=%0d expected 0/0", bad_start, bad_stop); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_back_to_back();
        test_div_change();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_loopback();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
